// File: rtl/uart_rx_frame_if.sv
// Serial line, frame configuration and receive results of uart_rx_frame.
// The master side drives the line; the slave side is the receiver.
`timescale 1ns/1ps
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 uart_rx;
    logic [2:0]           baud_set;
    logic [1:0]           parity_mode;
    logic [DATA_BITS-1:0] Data;
    logic                 Rx_Done;
    logic                 Parity_Err;
    logic                 Frame_Err;
    logic                 Busy;

    modport master (
        output uart_rx, baud_set, parity_mode,
        input  Data, Rx_Done, Parity_Err, Frame_Err, Busy
    );

    modport slave (
        input  uart_rx, baud_set, parity_mode,
        output Data, Rx_Done, Parity_Err, Frame_Err, Busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive engine: 16x oversampling, 7-sample majority vote per bit,
// runtime baud select, optional even/odd parity, one-cycle Rx_Done.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    uart_rx_frame_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_FREQ / (9600 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_FREQ / (19200 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_FREQ / (38400 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_FREQ / (57600 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_FREQ / (115200 * 16) - 1);
    localparam logic [DIV_W-1:0] DIV_230400 = DIV_W'(CLK_FREQ / (230400 * 16) - 1);
    localparam logic [3:0]       LAST_BIT   = 4'(DATA_BITS - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_edge;
    logic [2:0]           r_baud;
    logic [1:0]           r_par;
    logic [DIV_W-1:0]     r_div;
    logic [DIV_W-1:0]     w_div_max;
    logic [3:0]           r_sub;
    logic [3:0]           r_bit;
    logic [2:0]           r_vote;
    logic [2:0]           w_vote_now;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_pbit;
    logic                 r_stop;
    logic                 r_done;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 w_start;
    logic                 w_tick;
    logic                 w_bit_end;
    logic                 w_stop_pt;
    logic                 w_bit;
    logic                 w_par_en;
    logic                 w_par_exp;

    always_comb begin
        w_div_max = DIV_9600;
        unique case (r_baud)
            3'd1:    w_div_max = DIV_19200;
            3'd2:    w_div_max = DIV_38400;
            3'd3:    w_div_max = DIV_57600;
            3'd4:    w_div_max = DIV_115200;
            3'd5:    w_div_max = DIV_230400;
            default: w_div_max = DIV_9600;
        endcase
    end

    assign w_start    = (r_state == S_IDLE) && r_edge && !r_sync2;
    assign w_tick     = (r_state != S_IDLE) && (r_div == w_div_max);
    assign w_bit_end  = w_tick && (r_sub == 4'd15);
    assign w_stop_pt  = w_tick && (r_sub == 4'd11) && (r_state == S_STOP);
    assign w_vote_now = r_vote + {2'b00, r_sync2};
    assign w_bit      = (r_vote >= 3'd4);
    assign w_par_en   = (r_par == 2'd1) || (r_par == 2'd2);
    assign w_par_exp  = (^r_shift) ^ (r_par == 2'd2);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_start) w_next = S_START;
            S_START:  if (w_bit_end) w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_bit_end && r_bit == LAST_BIT)
                          w_next = w_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_next = S_STOP;
            S_STOP:   if (w_stop_pt) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_edge  <= 1'b1;
            r_baud  <= '0;
            r_par   <= '0;
            r_div   <= '0;
            r_sub   <= '0;
            r_bit   <= '0;
            r_vote  <= '0;
            r_shift <= '0;
            r_pbit  <= 1'b0;
            r_stop  <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= bus.uart_rx;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_done  <= 1'b0;
            if (w_start) begin
                r_baud <= bus.baud_set;
                r_par  <= bus.parity_mode;
                r_div  <= '0;
                r_sub  <= '0;
                r_bit  <= '0;
                r_vote <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                r_sub <= r_sub + 4'd1;
                if (r_sub == 4'd0)
                    r_vote <= '0;
                else if (r_sub >= 4'd5 && r_sub <= 4'd11)
                    r_vote <= w_vote_now;
                if (w_bit_end && r_state == S_DATA) begin
                    r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_bit   <= r_bit + 4'd1;
                end
                if (w_bit_end && r_state == S_PARITY)
                    r_pbit <= w_bit;
                // sub-tick 11 sample is not yet in r_vote, so use the live sum
                if (w_stop_pt)
                    r_stop <= (w_vote_now >= 3'd4);
            end else if (r_state != S_IDLE) begin
                r_div <= r_div + 1'b1;
            end
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                r_data <= r_shift;
                r_perr <= w_par_en && (r_pbit != w_par_exp);
                r_ferr <= !r_stop;
            end
        end
    end

    assign bus.Data       = r_data;
    assign bus.Rx_Done    = r_done;
    assign bus.Parity_Err = r_perr;
    assign bus.Frame_Err  = r_ferr;
    assign bus.Busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8-bit receiver at 50 MHz and a 7-bit one
// on a slow clock, driven with serial frames and checked against a model.
`timescale 1ns/1ps
module tb_uart_rx_frame;
    localparam int F8 = 50_000_000;
    localparam int F7 = 1_843_200;

    logic clk = 1'b0;
    logic rst8;
    logic rst7;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fall_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_if #(.DATA_BITS(8)) if8 ();
    uart_rx_frame_if #(.DATA_BITS(7)) if7 ();

    uart_rx_frame #(.CLK_FREQ(F8), .DATA_BITS(8), .DIV_W(16)) u_dut8 (
        .Clk(clk), .Reset(rst8), .bus(if8.slave)
    );
    uart_rx_frame #(.CLK_FREQ(F7), .DATA_BITS(7), .DIV_W(16)) u_dut7 (
        .Clk(clk), .Reset(rst7), .bus(if7.slave)
    );

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } rx_t;

    typedef struct {
        int         w;
        int         bs;
        int         pm;
        logic [8:0] d;
        logic       pb;
        logic       stop;
        int         gap;
        logic [8:0] xd;
        logic       xp;
        logic       xf;
    } vec_t;

    rx_t  q8[$];
    rx_t  q7[$];
    rx_t  m8;
    rx_t  m7;
    logic prev8 = 1'b0;
    logic prev7 = 1'b0;

    // collect every completed frame; a pulse wider than one cycle is an error
    always @(negedge clk) begin
        if (if8.Rx_Done === 1'b1) begin
            checks++;
            if (prev8) begin
                errors++;
                $display("FAIL pulse_width8 got 2+ cycles required 1");
            end
            m8.data = {1'b0, if8.Data};
            m8.perr = if8.Parity_Err;
            m8.ferr = if8.Frame_Err;
            m8.cyc  = cyc;
            q8.push_back(m8);
        end
        prev8 = if8.Rx_Done;
    end

    always @(negedge clk) begin
        if (if7.Rx_Done === 1'b1) begin
            checks++;
            if (prev7) begin
                errors++;
                $display("FAIL pulse_width7 got 2+ cycles required 1");
            end
            m7.data = {2'b00, if7.Data};
            m7.perr = if7.Parity_Err;
            m7.ferr = if7.Frame_Err;
            m7.cyc  = cyc;
            q7.push_back(m7);
        end
        prev7 = if7.Rx_Done;
    end

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int div_of(input int f, input int bs);
        int baud;
        case (bs)
            1:       baud = 19200;
            2:       baud = 38400;
            3:       baud = 57600;
            4:       baud = 115200;
            5:       baud = 230400;
            default: baud = 9600;
        endcase
        return f / (baud * 16) - 1;
    endfunction

    function automatic logic good_pbit(input int pm, input logic [8:0] d,
                                       input int nb);
        int ones;
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        return (pm == 2) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic logic model_perr(input int pm, input logic [8:0] d,
                                        input int nb, input logic pb);
        if (pm != 1 && pm != 2) return 1'b0;
        return pb != good_pbit(pm, d, nb);
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int w, input logic v);
        if (w == 0) if8.uart_rx = v;
        else        if7.uart_rx = v;
    endtask

    task automatic set_cfg(input int w, input int bs, input int pm);
        if (w == 0) begin
            if8.baud_set    = 3'(bs);
            if8.parity_mode = 2'(pm);
        end else begin
            if7.baud_set    = 3'(bs);
            if7.parity_mode = 2'(pm);
        end
    endtask

    task automatic send(input int w, input int bs, input int pm,
                        input logic [8:0] d, input logic pb,
                        input logic stop, input int gap);
        int nb;
        int bc;
        nb = (w == 0) ? 8 : 7;
        bc = 16 * (div_of((w == 0) ? F8 : F7, bs) + 1);
        set_cfg(w, bs, pm);
        drive(w, 1'b0);
        fall_cyc = cyc;
        hold(bc);
        // the frame must keep the configuration seen at its start edge
        set_cfg(w, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)));
        for (int i = 0; i < nb; i++) begin
            drive(w, d[i]);
            hold(bc);
        end
        if (pm == 1 || pm == 2) begin
            drive(w, pb);
            hold(bc);
        end
        drive(w, stop);
        hold(bc);
        drive(w, 1'b1);
        hold(gap);
    endtask

    task automatic get_rx(input int w, input int bound, output rx_t r,
                          output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        r.data = '0;
        r.perr = 1'b0;
        r.ferr = 1'b0;
        r.cyc  = 0;
        while (((w == 0) ? q8.size() : q7.size()) == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (w == 0 && q8.size() > 0) begin
            r = q8.pop_front();
            ok = 1'b1;
        end else if (w != 0 && q7.size() > 0) begin
            r = q7.pop_front();
            ok = 1'b1;
        end else begin
            checks++;
            errors++;
            $display("FAIL rx_timeout dut%0d got no Rx_Done required one", w);
        end
    endtask

    task automatic check_reset_outputs(input int w, input string tag);
        if (w == 0) begin
            cmp({tag, "_data8"}, 32'(if8.Data), 0);
            cmp({tag, "_done8"}, 32'(if8.Rx_Done), 0);
            cmp({tag, "_perr8"}, 32'(if8.Parity_Err), 0);
            cmp({tag, "_ferr8"}, 32'(if8.Frame_Err), 0);
            cmp({tag, "_busy8"}, 32'(if8.Busy), 0);
        end else begin
            cmp({tag, "_data7"}, 32'(if7.Data), 0);
            cmp({tag, "_done7"}, 32'(if7.Rx_Done), 0);
            cmp({tag, "_perr7"}, 32'(if7.Parity_Err), 0);
            cmp({tag, "_ferr7"}, 32'(if7.Frame_Err), 0);
            cmp({tag, "_busy7"}, 32'(if7.Busy), 0);
        end
    endtask

    vec_t tbl[10];

    initial begin
        rx_t  r;
        bit   ok;
        int   w;
        int   bs;
        int   pm;
        int   nb;
        int   gap;
        int   lat;
        logic [8:0] d;
        logic pb;
        logic stop;

        //          w  bs pm d        pb    stop  gap xd       xp    xf
        tbl[0] = '{0, 4, 0, 9'h0A5, 1'b0, 1'b1, 40, 9'h0A5, 1'b0, 1'b0};
        tbl[1] = '{0, 5, 1, 9'h037, 1'b0, 1'b1, 40, 9'h037, 1'b1, 1'b0};
        tbl[2] = '{0, 5, 1, 9'h037, 1'b1, 1'b1, 40, 9'h037, 1'b0, 1'b0};
        tbl[3] = '{0, 5, 0, 9'h05A, 1'b0, 1'b0, 40, 9'h05A, 1'b0, 1'b1};
        tbl[4] = '{0, 5, 2, 9'h080, 1'b0, 1'b1, 40, 9'h080, 1'b0, 1'b0};
        tbl[5] = '{0, 5, 3, 9'h0FF, 1'b0, 1'b1, 40, 9'h0FF, 1'b0, 1'b0};
        tbl[6] = '{1, 0, 2, 9'h000, 1'b1, 1'b1, 0,  9'h000, 1'b0, 1'b0};
        tbl[7] = '{1, 0, 2, 9'h07F, 1'b0, 1'b1, 0,  9'h07F, 1'b0, 1'b0};
        tbl[8] = '{1, 0, 2, 9'h02B, 1'b1, 1'b1, 0,  9'h02B, 1'b0, 1'b0};
        tbl[9] = '{1, 3, 1, 9'h055, 1'b1, 1'b1, 20, 9'h055, 1'b1, 1'b0};

        if8.uart_rx = 1'b1;
        if7.uart_rx = 1'b1;
        set_cfg(0, 0, 0);
        set_cfg(1, 0, 0);
        rst8 = 1'b1;
        rst7 = 1'b1;
        hold(4);
        check_reset_outputs(0, "reset");
        check_reset_outputs(1, "reset");
        rst8 = 1'b0;
        rst7 = 1'b0;
        hold(10);

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].w, tbl[i].bs, tbl[i].pm, tbl[i].d, tbl[i].pb,
                 tbl[i].stop, tbl[i].gap);
            get_rx(tbl[i].w, 3000, r, ok);
            if (ok) begin
                cmp($sformatf("vec%0d_data", i), 32'(r.data), 32'(tbl[i].xd));
                cmp($sformatf("vec%0d_perr", i), 32'(r.perr), 32'(tbl[i].xp));
                cmp($sformatf("vec%0d_ferr", i), 32'(r.ferr), 32'(tbl[i].xf));
            end
            if (i == 0) begin
                lat = (16 * 9 + 12) * (div_of(F8, 4) + 1) + 4;
                if (ok) cmp("latency_8n1", 32'(r.cyc - fall_cyc), 32'(lat));
                cmp("busy_after_frame", 32'(if8.Busy), 0);
            end
        end

        // false start: 3 sub-ticks low, then idle again
        set_cfg(0, 5, 0);
        drive(0, 1'b0);
        hold(3 * 13);
        drive(0, 1'b1);
        hold(5 * 13);
        cmp("false_start_busy", 32'(if8.Busy), 1);
        hold(2 * 16 * 13);
        cmp("false_start_idle", 32'(if8.Busy), 0);
        cmp("false_start_data", 32'(if8.Data), 32'h0FF);
        cmp("false_start_nodone", 32'(q8.size()), 0);

        // reset in the middle of data bit 4
        set_cfg(0, 5, 0);
        drive(0, 1'b0);
        hold(208);
        d = 9'h0AA;
        for (int i = 0; i < 4; i++) begin
            drive(0, d[i]);
            hold(208);
        end
        drive(0, d[4]);
        hold(104);
        rst8 = 1'b1;
        drive(0, 1'b1);
        hold(1);
        check_reset_outputs(0, "midreset");
        hold(3);
        rst8 = 1'b0;
        hold(12 * 208);
        cmp("midreset_nodone", 32'(q8.size()), 0);
        send(0, 5, 0, 9'h0C3, 1'b0, 1'b1, 30);
        get_rx(0, 3000, r, ok);
        if (ok) begin
            cmp("after_reset_data", 32'(r.data), 32'h0C3);
            cmp("after_reset_perr", 32'(r.perr), 0);
            cmp("after_reset_ferr", 32'(r.ferr), 0);
        end

        for (int i = 0; i < 12; i++) begin
            w    = i % 2;
            nb   = (w == 0) ? 8 : 7;
            bs   = (w == 0) ? int'($urandom_range(5, 4))
                            : int'($urandom_range(3, 0));
            pm   = int'($urandom_range(3, 0));
            d    = 9'($urandom) & 9'((1 << nb) - 1);
            pb   = ($urandom_range(1, 0) == 1) ? good_pbit(pm, d, nb)
                                               : 1'($urandom);
            stop = ($urandom_range(3, 0) != 0);
            gap  = stop ? int'($urandom_range(40, 0))
                        : int'($urandom_range(40, 4));
            send(w, bs, pm, d, pb, stop, gap);
            get_rx(w, 3000, r, ok);
            if (ok) begin
                cmp($sformatf("rnd%0d_data", i), 32'(r.data), 32'(d));
                cmp($sformatf("rnd%0d_perr", i), 32'(r.perr),
                    32'(model_perr(pm, d, nb, pb)));
                cmp($sformatf("rnd%0d_ferr", i), 32'(r.ferr), 32'(!stop));
            end
        end

        hold(500);
        cmp("no_extra_done8", 32'(q8.size()), 0);
        cmp("no_extra_done7", 32'(q7.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive engine: next generation of the byte receiver in the UART control path. Recovers asynchronous serial frames with configurable data width, parity and runtime baud selection, using 16x oversampling with 7-sample majority vote per bit. Delivers each frame as a one-cycle `Rx_Done` pulse with held data and parity/framing error flags to the command decoder (LED control and later UART clients).

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz, used for all divisor constants.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `DIV_W`, 16: width of the oversample divider counter; must hold the largest divisor.
- `Clk` input 1: system clock; all logic on rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `uart_rx` input 1: asynchronous serial line, idle high.
- `baud_set` input 3: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400; 6 and 7 select 9600.
- `parity_mode` input 2: 0=none, 1=even, 2=odd, 3=none.
- `Data` output DATA_BITS: last received data word, LSB = first bit on the line.
- `Rx_Done` output 1: one-cycle pulse when a frame completes.
- `Parity_Err` output 1: parity mismatch for the frame reported with the last `Rx_Done`.
- `Frame_Err` output 1: stop bit sampled low for the frame reported with the last `Rx_Done`.
- `Busy` output 1: high while a frame is being received.

## Operation
- Input path: `uart_rx` passes through a 2-flop synchroniser, then one edge flop. Start is detected when the synchronised line is 1 then 0 (falling edge).
- Divisor: DIV = CLK_FREQ/(baud*16) - 1, integer division, constants selected combinationally from `baud_set`. At 50 MHz: 9600→324, 115200→26, 230400→12.
- Frame capture: `baud_set` and `parity_mode` are latched on the start-detect cycle and held for the whole frame.
- Tick generation: the divider counts 0..DIV while not IDLE. A tick fires when the count equals DIV, then the count wraps to 0. The divider is cleared on start detection.
- Sub-bit counter: counts 0..15 on ticks. On sub-ticks 5..11 the synchronised line is added into a 3-bit vote counter. Bit value = (vote >= 4). The vote counter clears at sub-tick 0 of each bit.
- FSM states and transitions:
  - IDLE → START on falling edge.
  - START, after sub-tick 15: vote >= 4 is a false start → IDLE, no `Rx_Done`; otherwise → DATA.
  - DATA: DATA_BITS bits shifted LSB-first into a shift register → PARITY if parity is enabled, else → STOP.
  - PARITY: one bit. Expected value is XOR of the data bits for even, its inverse for odd.
  - STOP: decided at sub-tick 11 (not 15), so a back-to-back start edge is never missed. On the next cycle: `Rx_Done`=1, `Data`, `Parity_Err` and `Frame_Err` update, → IDLE.
- `Parity_Err`=0 whenever parity is disabled. `Data`, `Parity_Err` and `Frame_Err` hold until the next completed frame; a false start leaves them unchanged.
- Falling edges while not in IDLE are ignored.
- `Busy`=1 in every state except IDLE.
- Reset: all outputs 0, FSM → IDLE, counters 0, synchroniser flops 1 (idle line). Reset mid-frame abandons the frame with no `Rx_Done`.

## Timing
- Start detect: the edge is seen 3 clocks after the line falls at the synchroniser input.
- Tick period = DIV+1 clocks; bit period = 16*(DIV+1).
- `Rx_Done` asserts (1+DATA_BITS+P)*16*(DIV+1) + 12*(DIV+1) + 1 clocks after start detect, where P=1 with parity enabled and 0 without.
- `Rx_Done` is exactly 1 cycle wide; outputs are valid in the same cycle and remain stable afterwards.
- Minimum frame-to-frame spacing: a new start edge is accepted from the cycle after `Rx_Done`.
- Line sampled mid-bit ±3 sub-ticks; tolerates ±3% baud mismatch at 8N1.

## Test plan
- 50 MHz, `baud_set`=4, 8N1, byte 0xA5 → one `Rx_Done`, `Data`=0xA5, `Parity_Err`=0, `Frame_Err`=0, `Busy` low after.
- `parity_mode`=1, 0x37 with parity bit 0 (correct is 1) → `Data`=0x37, `Parity_Err`=1. Repeat with bit 1 → `Parity_Err`=0.
- Line low for 3 sub-ticks then high → no `Rx_Done`, FSM back in IDLE, previous `Data` unchanged.
- 0x5A sent with stop bit driven low → `Rx_Done`, `Data`=0x5A, `Frame_Err`=1.
- `DATA_BITS`=7, `parity_mode`=2, `baud_set`=0: frames 0x00, 0x7F, 0x2B sent back-to-back with zero idle → three `Rx_Done` pulses, correct data, no errors.
- `Reset` pulsed at data bit 4 of a frame, then 0xC3 sent → no pulse for the aborted frame, `Data`=0xC3 on the next frame. Outputs read 0 during reset.
